pam4_frame_sync: RTL and testbench

PAM4_FRAME_SYNC -- requirements
Module: pam4_frame_sync

---
 rtl/pam4_pkg.sv | 28 ++
 rtl/pam4_gray_demap.sv | 31 +++
 rtl/pam4_frame_sync.sv | 136 +++++++++++++
 tb/tb_pam4_frame_sync.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pam4_pkg.sv
// ============================================================================
// Module : pam4_pkg
// Brief  : Shared frame-sync state encoding, PAM4 levels and Gray bit pairs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pam4_pkg;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOCK  = 2'd2
    } sync_state_e;

    localparam logic signed [3:0] c_LVL_M3 = -4'sd3;
    localparam logic signed [3:0] c_LVL_M1 = -4'sd1;
    localparam logic signed [3:0] c_LVL_P1 =  4'sd1;
    localparam logic signed [3:0] c_LVL_P3 =  4'sd3;

    localparam logic [1:0] c_GRAY_M3 = 2'b00;
    localparam logic [1:0] c_GRAY_M1 = 2'b01;
    localparam logic [1:0] c_GRAY_P1 = 2'b11;
    localparam logic [1:0] c_GRAY_P3 = 2'b10;

endpackage

`default_nettype wire

// File: rtl/pam4_gray_demap.sv
// ============================================================================
// Module : pam4_gray_demap
// Brief  : Combinational PAM4 -> Gray bit-pair demapper with illegal flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pam4_gray_demap
    import pam4_pkg::*;
(
    input  logic signed [3:0] i_sym,
    output logic        [1:0] o_bits,
    output logic              o_illegal
);

    // Any code outside the four levels decodes as 00 so the stream stays aligned.
    always_comb begin
        o_bits    = c_GRAY_M3;
        o_illegal = 1'b0;
        case (i_sym)
            c_LVL_M3: o_bits = c_GRAY_M3;
            c_LVL_M1: o_bits = c_GRAY_M1;
            c_LVL_P1: o_bits = c_GRAY_P1;
            c_LVL_P3: o_bits = c_GRAY_P3;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pam4_frame_sync.sv
// ============================================================================
// Module : pam4_frame_sync
// Brief  : PAM4 symbol demap, frame sync hunt/check/lock and payload extraction.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pam4_frame_sync
    import pam4_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD     = 8'hB8,
    parameter int         PAYLOAD_BYTES = 7,
    parameter int         LOCK_CNT      = 2,
    parameter int         UNLOCK_CNT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sym_en,
    input  logic signed [3:0] sym,
    output logic        [7:0] dout,
    output logic              dout_valid,
    output logic              sof,
    output logic              locked,
    output logic        [1:0] state,
    output logic       [15:0] sym_err_cnt
);

    localparam int         c_FRAME_SYMS = 4 * (1 + PAYLOAD_BYTES);
    localparam logic [7:0] c_LAST_SYM   = 8'(c_FRAME_SYMS - 1);
    localparam logic [7:0] c_PAY_END    = 8'(4 * PAYLOAD_BYTES);
    localparam logic [7:0] c_LOCK_CNT   = 8'(LOCK_CNT);
    localparam logic [7:0] c_UNLOCK_CNT = 8'(UNLOCK_CNT);

    sync_state_e r_state;
    logic [7:0]  r_sr;
    logic [7:0]  r_sym_cnt;
    logic [7:0]  r_good_cnt;
    logic [7:0]  r_miss_cnt;
    logic [7:0]  r_dout;
    logic        r_dout_valid;
    logic        r_sof;
    logic [15:0] r_err_cnt;

    logic [1:0]  w_bits;
    logic        w_illegal;
    logic [7:0]  w_sr_next;
    logic        w_sync_hit;
    logic        w_byte_slot;
    logic [7:0]  w_good_inc;
    logic [7:0]  w_miss_inc;

    pam4_gray_demap u_demap (
        .i_sym     (sym),
        .o_bits    (w_bits),
        .o_illegal (w_illegal)
    );

    assign w_sr_next   = {r_sr[5:0], w_bits};
    assign w_sync_hit  = (w_sr_next == SYNC_WORD);
    assign w_byte_slot = (r_sym_cnt[1:0] == 2'b11) && (r_sym_cnt < c_PAY_END);
    assign w_good_inc  = r_good_cnt + 8'd1;
    assign w_miss_inc  = r_miss_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_sr         <= 8'd0;
            r_sym_cnt    <= 8'd0;
            r_good_cnt   <= 8'd0;
            r_miss_cnt   <= 8'd0;
            r_dout       <= 8'd0;
            r_dout_valid <= 1'b0;
            r_sof        <= 1'b0;
            r_err_cnt    <= 16'd0;
        end else begin
            r_dout_valid <= 1'b0;
            r_sof        <= 1'b0;
            if (sym_en) begin
                r_sr <= w_sr_next;
                if (w_illegal && (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
                case (r_state)
                    ST_HUNT: begin
                        if (w_sync_hit) begin
                            r_state    <= ST_CHECK;
                            r_sym_cnt  <= 8'd0;
                            r_good_cnt <= 8'd0;
                        end
                    end
                    default: begin
                        // Bytes complete on every 4th payload symbol of a locked frame.
                        if ((r_state == ST_LOCK) && w_byte_slot) begin
                            r_dout       <= w_sr_next;
                            r_dout_valid <= 1'b1;
                            r_sof        <= (r_sym_cnt == 8'd3);
                        end
                        if (r_sym_cnt == c_LAST_SYM) begin
                            r_sym_cnt <= 8'd0;
                            if (r_state == ST_CHECK) begin
                                if (w_sync_hit) begin
                                    r_good_cnt <= w_good_inc;
                                    if (w_good_inc == c_LOCK_CNT) begin
                                        r_state    <= ST_LOCK;
                                        r_miss_cnt <= 8'd0;
                                    end
                                end else begin
                                    r_state <= ST_HUNT;
                                end
                            end else if (w_sync_hit) begin
                                r_miss_cnt <= 8'd0;
                            end else begin
                                r_miss_cnt <= w_miss_inc;
                                if (w_miss_inc == c_UNLOCK_CNT) begin
                                    r_state <= ST_HUNT;
                                end
                            end
                        end else begin
                            r_sym_cnt <= r_sym_cnt + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign sof         = r_sof;
    assign locked      = (r_state == ST_LOCK);
    assign state       = r_state;
    assign sym_err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pam4_frame_sync.sv
// ============================================================================
// Module : tb_pam4_frame_sync
// Brief  : Randomized self-checking bench for pam4_frame_sync with a stream model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pam4_frame_sync;

    localparam int         P    = 7;
    localparam int         FS   = 4 * (1 + P);
    localparam int         SYNC = 8'hB8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sym_en = 1'b0;
    logic signed [3:0] sym = 4'sd0;
    logic        [7:0] dout;
    logic              dout_valid;
    logic              sof;
    logic              locked;
    logic        [1:0] state;
    logic       [15:0] sym_err_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: frame position, sync history and the byte window.
    int m_state, m_pos, m_good, m_miss, m_sr, m_err, m_dout;
    bit m_v, m_sof;
    int sq[$];
    int pl[P];

    pam4_frame_sync dut (
        .clk         (clk),
        .rst         (rst),
        .sym_en      (sym_en),
        .sym         (sym),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .sof         (sof),
        .locked      (locked),
        .state       (state),
        .sym_err_cnt (sym_err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int lvl(input int b);
        case (b)
            0:       return -3;
            1:       return -1;
            3:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic push_byte(input int b);
        for (int k = 3; k >= 0; k--) sq.push_back(lvl((b >> (2 * k)) & 3));
    endtask

    task automatic push_frame(input bit good);
        push_byte(good ? SYNC : 8'h00);
        for (int i = 0; i < P; i++) push_byte(pl[i]);
    endtask

    // Payload bytes 00xxxxxx (excluding 0x2E) cannot mimic the sync word at any offset.
    task automatic rand_payload();
        for (int i = 0; i < P; i++) begin
            pl[i] = int'($urandom_range(0, 63));
            if (pl[i] == 8'h2E) pl[i] = 8'h2F;
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_good = 0; m_miss = 0;
        m_sr = 0; m_err = 0; m_dout = 0; m_v = 0; m_sof = 0;
    endtask

    task automatic model_sym(input int s);
        int b;
        bit ill;
        ill = 0;
        case (s)
            -3:      b = 0;
            -1:      b = 1;
            1:       b = 3;
            3:       b = 2;
            default: begin b = 0; ill = 1; end
        endcase
        if (ill && m_err < 65535) m_err++;
        m_sr = ((m_sr * 4) + b) % 256;
        if (m_state == 0) begin
            if (m_sr == SYNC) begin m_state = 1; m_pos = 0; m_good = 0; end
        end else begin
            if (m_state == 2 && m_pos < 4 * P && m_pos % 4 == 3) begin
                m_v = 1; m_sof = (m_pos == 3); m_dout = m_sr;
            end
            if (m_pos == FS - 1) begin
                m_pos = 0;
                if (m_state == 1) begin
                    if (m_sr == SYNC) begin
                        m_good++;
                        if (m_good == 2) begin m_state = 2; m_miss = 0; end
                    end else m_state = 0;
                end else if (m_sr == SYNC) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss == 3) m_state = 0;
                end
            end else m_pos++;
        end
    endtask

    task automatic step(input bit en, input int s, input bit r);
        @(negedge clk);
        sym_en = en; sym = 4'(s); rst = r;
        @(posedge clk);
        #1;
        m_v = 0; m_sof = 0;
        if (r) model_reset();
        else if (en) model_sym(s);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            n_vec++;
            if ({dout, dout_valid, sof, locked, state, sym_err_cnt} !== 29'd0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got dout=%h v=%b sof=%b lk=%b st=%0d err=%0d want all 0",
                         i, dout, dout_valid, sof, locked, state, sym_err_cnt);
            end
        end
    endtask

    task automatic test_lock();
        int npulse, idx;
        bit sof_ok, val_ok;
        npulse = 0; idx = 0; sof_ok = 0; val_ok = 1;
        for (int i = 0; i < P; i++) pl[i] = 8'h1E;
        for (int f = 0; f < 3; f++) push_frame(1);
        while (sq.size() > 0) begin
            step(1, sq.pop_front(), 0);
            n_vec++;
            if (dout_valid !== m_v || sof !== m_sof || dout !== 8'(m_dout) || state !== 2'(m_state)
                || locked !== (m_state == 2)) begin
                n_bad++;
                $display("FAIL lock_sym %0d got v=%b sof=%b d=%h st=%0d want v=%b sof=%b d=%h st=%0d",
                         idx, dout_valid, sof, dout, state, m_v, m_sof, 8'(m_dout), m_state);
            end
            if (dout_valid) begin
                npulse++;
                if (npulse == 1) sof_ok = sof;
                if (dout !== 8'h1E) val_ok = 0;
            end
            if (idx == 3) begin
                n_vec++;
                if (state !== 2'd1) begin
                    n_bad++;
                    $display("FAIL first_sync_check got st=%0d want 1", state);
                end
            end
            idx++;
            step(0, 0, 0);
            n_vec++;
            if (dout_valid !== 1'b0 || state !== 2'(m_state)) begin
                n_bad++;
                $display("FAIL lock_idle got v=%b st=%0d want v=0 st=%0d", dout_valid, state, m_state);
            end
        end
        n_vec++;
        if (npulse != 7 || !sof_ok || !val_ok || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_payload got pulses=%0d sof1=%b vals_ok=%b lk=%b want 7 1 1 1",
                     npulse, sof_ok, val_ok, locked);
        end
    endtask

    task automatic test_miss();
        bit goods[8]  = '{0, 0, 1, 0, 0, 0, 1, 1};
        bit exp_lk[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        int late_pulses;
        late_pulses = 0;
        for (int f = 0; f < 8; f++) begin
            rand_payload();
            push_frame(goods[f]);
            while (sq.size() > 0) begin
                step(1, sq.pop_front(), 0);
                n_vec++;
                if (dout_valid !== m_v || sof !== m_sof || dout !== 8'(m_dout) || state !== 2'(m_state)) begin
                    n_bad++;
                    $display("FAIL miss_sym f=%0d got v=%b sof=%b d=%h st=%0d want v=%b sof=%b d=%h st=%0d",
                             f, dout_valid, sof, dout, state, m_v, m_sof, 8'(m_dout), m_state);
                end
                if (f >= 5 && dout_valid) late_pulses++;
                if ($urandom_range(0, 1) == 1) step(0, 0, 0);
            end
            n_vec++;
            if (locked !== exp_lk[f]) begin
                n_bad++;
                $display("FAIL miss_lock f=%0d got lk=%b want %b", f, locked, exp_lk[f]);
            end
        end
        n_vec++;
        if (late_pulses != 0 || state === 2'd2) begin
            n_bad++;
            $display("FAIL unlock_quiet got pulses=%0d st=%0d want 0 pulses, not LOCK", late_pulses, state);
        end
    endtask

    task automatic test_sym_err();
        int ill[5] = '{0, 2, 0, 2, 0};
        step(0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, ill[i], 0);
            n_vec++;
            if (sym_err_cnt !== 16'(m_err) || state !== 2'(m_state)) begin
                n_bad++;
                $display("FAIL err_step %0d got err=%0d st=%0d want err=%0d st=%0d",
                         i, sym_err_cnt, state, m_err, m_state);
            end
        end
        n_vec++;
        if (sym_err_cnt !== 16'd5) begin
            n_bad++;
            $display("FAIL err_five got %0d want 5", sym_err_cnt);
        end
        // An illegal code closing +3,+1,+3 must complete the sync word as 00.
        step(1, 3, 0); step(1, 1, 0); step(1, 3, 0); step(1, 2, 0);
        n_vec++;
        if (state !== 2'd1 || sym_err_cnt !== 16'd6) begin
            n_bad++;
            $display("FAIL err_demap00 got st=%0d err=%0d want st=1 err=6", state, sym_err_cnt);
        end
        for (int i = 0; i < 65534 - 6; i++) step(1, 0, 0);
        n_vec++;
        if (sym_err_cnt !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL err_fffe got %h want fffe", sym_err_cnt);
        end
        for (int i = 0; i < 3; i++) step(1, 2, 0);
        n_vec++;
        if (sym_err_cnt !== 16'hFFFF || m_err != 65535) begin
            n_bad++;
            $display("FAIL err_sat got %h want ffff", sym_err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 1);
        for (int f = 0; f < 5; f++) begin
            rand_payload();
            push_frame(1);
        end
        // Drop the tail of the last frame so reset lands six symbols into its payload.
        repeat (4 * P - 6) void'(sq.pop_back());
        while (sq.size() > 0) begin
            step(1, sq.pop_front(), 0);
            n_vec++;
            if (dout_valid !== m_v || sof !== m_sof || dout !== 8'(m_dout) || state !== 2'(m_state)) begin
                n_bad++;
                $display("FAIL b2b_sym got v=%b sof=%b d=%h st=%0d want v=%b sof=%b d=%h st=%0d",
                         dout_valid, sof, dout, state, m_v, m_sof, 8'(m_dout), m_state);
            end
        end
        n_vec++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_locked got %b want 1", locked);
        end
        step(1, 3, 1);
        n_vec++;
        if ({dout, dout_valid, sof, locked, state, sym_err_cnt} !== 29'd0) begin
            n_bad++;
            $display("FAIL midbyte_rst got dout=%h v=%b sof=%b lk=%b st=%0d err=%0d want all 0",
                     dout, dout_valid, sof, locked, state, sym_err_cnt);
        end
        step(1, -3, 0);
        n_vec++;
        if (dout_valid !== 1'b0 || state !== 2'd0) begin
            n_bad++;
            $display("FAIL post_rst got v=%b st=%0d want v=0 st=0", dout_valid, state);
        end
    endtask

    task automatic test_offset();
        int want[$];
        int got[$];
        step(0, 0, 1);
        sq.push_back(lvl(int'($urandom_range(0, 3))));
        for (int f = 0; f < 4; f++) begin
            rand_payload();
            push_frame(1);
            if (f >= 2) for (int i = 0; i < P; i++) want.push_back(pl[i]);
        end
        while (sq.size() > 0) begin
            step(1, sq.pop_front(), 0);
            if (dout_valid) got.push_back(int'(dout));
            if ($urandom_range(0, 2) == 0) step(0, 0, 0);
        end
        n_vec++;
        if (locked !== 1'b1 || got.size() != want.size()) begin
            n_bad++;
            $display("FAIL offset_lock got lk=%b bytes=%0d want lk=1 bytes=%0d", locked, got.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < got.size(); i++) begin
            n_vec++;
            if (got[i] != want[i]) begin
                n_bad++;
                $display("FAIL offset_byte %0d got %h want %h", i, got[i], want[i]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_miss();
        test_sym_err();
        test_back_to_back();
        test_offset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
